mem_arbiter: RTL

Memory-side responder for the datapath's instruction/data request interface. Accepts the pipeline's instruction-fetch and data load/store requests, serializes them onto a single-port RAM with variable latency, and returns one-cycle `ihit`/`dhit` pulses with registered read data. It sits between the pipelined datapath and main memory, and keeps saturating access counters for performance accounting.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_sat_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
// Provides the 32-bit word type, the memory-arbiter state encoding and the
// fill word returned when a RAM access is abandoned.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IACC = 3'd1,
        DACC = 3'd2,
        IHIT = 3'd3,
        DHIT = 3'd4
    } arb_state_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the datapath, mem_arbiter and the RAM.
// Ports (slave = arbiter view):
//   in : imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
//        ramload, ram_ready
//   out: ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore,
//        timeout_err, icount, dcount
// The master modport is the mirror image (datapath plus RAM model side).
interface mem_arbiter_if #(
    parameter int CNT_W = 16
);
    import cpu_types_pkg::*;

    logic             imemREN;
    word_t            imemaddr;
    logic             dmemREN;
    logic             dmemWEN;
    word_t            dmemaddr;
    word_t            dmemstore;
    logic             halt;
    logic             ihit;
    word_t            imemload;
    logic             dhit;
    word_t            dmemload;
    logic             ramREN;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    word_t            ramload;
    logic             ram_ready;
    logic             timeout_err;
    logic [CNT_W-1:0] icount;
    logic [CNT_W-1:0] dcount;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ramload, ram_ready,
        output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr,
        output ramstore, timeout_err, icount, dcount
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ramload, ram_ready,
        input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr,
        input  ramstore, timeout_err, icount, dcount
    );

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter.
// Ports:
//   i_clk   : clock
//   i_clr   : synchronous clear (active high), wins over i_inc
//   i_inc   : increment by one unless already all-ones
//   o_count : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side responder: serialises instruction fetches and data accesses
// onto one single-port, variable-latency RAM and returns one-cycle hit
// pulses with registered read data.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : mem_arbiter_if slave modport (datapath requests, RAM strobes and
//         responses, hit pulses, sticky timeout flag, access counters)
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    word_t             r_addr;
    word_t             r_store;
    word_t             r_imemload;
    word_t             r_dmemload;
    logic              r_is_write;
    logic              r_last_d;
    logic              r_timeout_err;
    logic [WAIT_W-1:0] r_wait;

    logic              w_dreq;
    logic              w_ireq;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_in_acc;
    logic              w_timeout;
    logic              w_done;
    logic [1:0]        w_cnt_inc;
    logic [CNT_W-1:0]  w_cnt [2];
    logic              w_unused;

    assign w_dreq    = bus.dmemREN | bus.dmemWEN;
    assign w_ireq    = bus.imemREN & ~bus.halt;
    assign w_in_acc  = (r_state == IACC) || (r_state == DACC);
    // r_wait counts completed ACC cycles; the access is abandoned in the
    // ACC cycle that sees TIMEOUT earlier cycles without ram_ready.
    assign w_timeout = w_in_acc && !bus.ram_ready && (r_wait == WAIT_W'(TIMEOUT));
    assign w_done    = w_in_acc && (bus.ram_ready || w_timeout);

    // Word-address low bits are deliberately discarded.
    assign w_unused  = ^{bus.imemaddr[1:0], bus.dmemaddr[1:0]};

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Under contention alternate with respect to the last grant.
                if (w_dreq && w_ireq) begin
                    w_grant_i = r_last_d;
                    w_grant_d = ~r_last_d;
                end else begin
                    w_grant_i = w_ireq;
                    w_grant_d = w_dreq;
                end
                if (w_grant_i) begin
                    w_state_next = IACC;
                end else if (w_grant_d) begin
                    w_state_next = DACC;
                end
            end
            IACC: if (w_done) w_state_next = IHIT;
            DACC: if (w_done) w_state_next = DHIT;
            IHIT: w_state_next = IDLE;
            DHIT: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr        <= '0;
            r_store       <= '0;
            r_is_write    <= 1'b0;
            r_last_d      <= 1'b0;
            r_wait        <= '0;
            r_imemload    <= '0;
            r_dmemload    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_grant_i) begin
                r_addr     <= {bus.imemaddr[31:2], 2'b00};
                r_is_write <= 1'b0;
                r_last_d   <= 1'b0;
                r_wait     <= '0;
            end else if (w_grant_d) begin
                r_addr     <= {bus.dmemaddr[31:2], 2'b00};
                r_store    <= bus.dmemstore;
                // A simultaneous read+write request is a write.
                r_is_write <= bus.dmemWEN;
                r_last_d   <= 1'b1;
                r_wait     <= '0;
            end else if (w_in_acc && !w_done) begin
                r_wait <= r_wait + WAIT_W'(1);
            end

            if (w_done && (r_state == IACC)) begin
                r_imemload <= bus.ram_ready ? bus.ramload : BAD_WORD;
            end
            if (w_done && (r_state == DACC) && !r_is_write) begin
                r_dmemload <= bus.ram_ready ? bus.ramload : BAD_WORD;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign w_cnt_inc[0] = (r_state == IHIT);
    assign w_cnt_inc[1] = (r_state == DHIT);

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .i_clk   (CLK),
            .i_clr   (RST),
            .i_inc   (w_cnt_inc[gi]),
            .o_count (w_cnt[gi])
        );
    end

    // Everything below is decoded from the state register or registered.
    assign bus.ihit        = (r_state == IHIT);
    assign bus.dhit        = (r_state == DHIT);
    assign bus.imemload    = r_imemload;
    assign bus.dmemload    = r_dmemload;
    assign bus.ramREN      = (r_state == IACC) || ((r_state == DACC) && !r_is_write);
    assign bus.ramWEN      = (r_state == DACC) && r_is_write;
    assign bus.ramaddr     = r_addr;
    assign bus.ramstore    = r_store;
    assign bus.timeout_err = r_timeout_err;
    assign bus.icount      = w_cnt[0];
    assign bus.dcount      = w_cnt[1];

endmodule
